// File: rtl/pht_update_scheduler.sv
// -----------------------------------------------------------------------------
// pht_update_scheduler
//
// Purpose:
//   Moves 2-bit pattern-history-table counter updates from branch resolution
//   onto the banked PHT write ports. A write is never issued to a bank that a
//   fetch-side read is using in the same cycle. Updates that cannot be written
//   immediately are held in an in-order circular queue and drained as soon as
//   their bank is free. Program order is preserved: the queue drains strictly
//   in order, and a newly arriving update never overtakes queued ones.
//
// Optional feature:
//   RSD_PHT_UPDATE_BYPASS_EN - when defined, updates that arrive while the queue
//   is empty may be written in the same cycle (zero-latency bypass). When it is
//   undefined, every valid update goes through the queue, so the minimum
//   latency is one cycle.
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   rdValid    in   [READ_NUM]            fetch read port i active this cycle
//   rdIndex    in   [READ_NUM*INDEX_WIDTH] fetch read indices (slot i at i*INDEX_WIDTH)
//   upValid    in   [WRITE_NUM]           update slot i valid (slot 0 is oldest)
//   upIndex    in   [WRITE_NUM*INDEX_WIDTH] update PHT indices
//   upValue    in   [WRITE_NUM*2]         new 2-bit counter values
//   wrValid    out  [WRITE_NUM]           PHT write port j active
//   wrIndex    out  [WRITE_NUM*INDEX_WIDTH] write indices (0 on unused ports)
//   wrValue    out  [WRITE_NUM*2]         write values (0 on unused ports)
//   count      out  queue occupancy
//   full       out  count == QUEUE_SIZE
//   dropped    out  one or more updates discarded this cycle (combinational)
//   dropCount  out  [16] saturating total of discarded updates
// -----------------------------------------------------------------------------
module pht_update_scheduler #(
  parameter int READ_NUM    = 2,
  parameter int WRITE_NUM   = 2,
  parameter int INDEX_WIDTH = 10,
  parameter int BANK_BITS   = 1,
  parameter int QUEUE_SIZE  = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [READ_NUM-1:0]              rdValid,
  input  logic [READ_NUM*INDEX_WIDTH-1:0]  rdIndex,
  input  logic [WRITE_NUM-1:0]             upValid,
  input  logic [WRITE_NUM*INDEX_WIDTH-1:0] upIndex,
  input  logic [WRITE_NUM*2-1:0]           upValue,
  output logic [WRITE_NUM-1:0]             wrValid,
  output logic [WRITE_NUM*INDEX_WIDTH-1:0] wrIndex,
  output logic [WRITE_NUM*2-1:0]           wrValue,
  output logic [$clog2(QUEUE_SIZE+1)-1:0]  count,
  output logic                             full,
  output logic                             dropped,
  output logic [15:0]                      dropCount
);

  localparam int PTR_W    = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam int CNT_W    = $clog2(QUEUE_SIZE+1);
  localparam int BANK_NUM = 1 << BANK_BITS;
  localparam int SLOT_W   = $clog2(WRITE_NUM+1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [BANK_BITS-1:0] f_bank(input logic [INDEX_WIDTH-1:0] idx);
    return idx[BANK_BITS-1:0];
  endfunction

  // Advance a queue pointer by k (k never exceeds QUEUE_SIZE), wrapping at
  // QUEUE_SIZE so that non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= QUEUE_SIZE) s = s - QUEUE_SIZE;
    return PTR_W'(s);
  endfunction

  function automatic logic [15:0] f_satAdd(input logic [15:0] a, input logic [SLOT_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0] r_qIndex [QUEUE_SIZE];
  logic [1:0]             r_qValue [QUEUE_SIZE];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;
  logic [15:0]            r_dropCount;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [BANK_NUM-1:0]              w_rdBusy;
  logic [WRITE_NUM-1:0]             w_wrValid;
  logic [WRITE_NUM*INDEX_WIDTH-1:0] w_wrIndex;
  logic [WRITE_NUM*2-1:0]           w_wrValue;
  logic [SLOT_W-1:0]                w_drainNum;
  logic [WRITE_NUM-1:0]             w_enqReq;
  logic [WRITE_NUM-1:0]             w_enqSel;
  logic [PTR_W-1:0]                 w_enqPtr [WRITE_NUM];
  logic [SLOT_W-1:0]                w_enqNum;
  logic [SLOT_W-1:0]                w_dropNum;
  logic                             w_unusedRdBits;

  // Only the bank bits of a read index matter here; the rest go to the RAM.
  assign w_unusedRdBits = ^rdIndex;

  // Banks occupied by this cycle's fetch reads.
  always_comb begin
    w_rdBusy = '0;
    for (int i = 0; i < READ_NUM; i++) begin
      if (rdValid[i]) w_rdBusy[f_bank(rdIndex[i*INDEX_WIDTH +: INDEX_WIDTH])] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-port grant: in-order drain first, then (optionally) bypass.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [BANK_NUM-1:0]    busy;
    logic                   stop;
    logic [SLOT_W-1:0]      nGrant;
    logic [PTR_W-1:0]       ptr;
    logic [INDEX_WIDTH-1:0] idx;

    w_wrValid  = '0;
    w_wrIndex  = '0;
    w_wrValue  = '0;
    w_drainNum = '0;
    w_enqReq   = '0;
    busy       = w_rdBusy;
    stop       = 1'b0;
    nGrant     = '0;
    ptr        = '0;
    idx        = '0;

    // Drain: the first blocked entry stops the drain so that no later entry
    // can overtake it. Because of that, drained entries fill ports 0..n-1
    // contiguously and port number equals queue offset.
    for (int k = 0; k < WRITE_NUM; k++) begin
      ptr = f_wrap(r_head, k);
      idx = r_qIndex[ptr];
      if (!stop && (k < int'(r_count))) begin
        if (busy[f_bank(idx)]) begin
          stop = 1'b1;
        end else begin
          w_wrValid[k]                          = 1'b1;
          w_wrIndex[k*INDEX_WIDTH +: INDEX_WIDTH] = idx;
          w_wrValue[k*2 +: 2]                   = r_qValue[ptr];
          busy[f_bank(idx)]                     = 1'b1;
          nGrant                                = nGrant + SLOT_W'(1);
        end
      end
    end
    w_drainNum = nGrant;

`ifdef RSD_PHT_UPDATE_BYPASS_EN
    // Bypass only when nothing is queued; once one update misses, it and all
    // younger slots go to the queue to keep per-index program order.
    stop = (r_count != '0);
    for (int i = 0; i < WRITE_NUM; i++) begin
      if (upValid[i]) begin
        idx = upIndex[i*INDEX_WIDTH +: INDEX_WIDTH];
        if (!stop && (int'(nGrant) < WRITE_NUM) && !busy[f_bank(idx)]) begin
          for (int j = 0; j < WRITE_NUM; j++) begin
            if (j == int'(nGrant)) begin
              w_wrValid[j]                          = 1'b1;
              w_wrIndex[j*INDEX_WIDTH +: INDEX_WIDTH] = idx;
              w_wrValue[j*2 +: 2]                   = upValue[i*2 +: 2];
            end
          end
          busy[f_bank(idx)] = 1'b1;
          nGrant            = nGrant + SLOT_W'(1);
        end else begin
          stop        = 1'b1;
          w_enqReq[i] = 1'b1;
        end
      end
    end
`else
    w_enqReq = upValid;
`endif
  end

  // ---------------------------------------------------------------------------
  // Enqueue selection. Slots freed by this cycle's drain are usable for this
  // cycle's enqueue. Keeping the first 'cap' requests in slot order is the
  // same as dropping the highest slots first.
  // ---------------------------------------------------------------------------
  always_comb begin
    int                cap;
    logic [SLOT_W-1:0] n;

    cap       = QUEUE_SIZE - int'(r_count) + int'(w_drainNum);
    n         = '0;
    w_enqSel  = '0;
    w_dropNum = '0;
    for (int i = 0; i < WRITE_NUM; i++) begin
      w_enqPtr[i] = f_wrap(r_tail, int'(n));
      if (w_enqReq[i]) begin
        if (int'(n) < cap) begin
          w_enqSel[i] = 1'b1;
          n           = n + SLOT_W'(1);
        end else begin
          w_dropNum = w_dropNum + SLOT_W'(1);
        end
      end
    end
    w_enqNum = n;
  end

  // ---------------------------------------------------------------------------
  // Queue payload storage (no reset: occupancy is tracked by the pointers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < WRITE_NUM; i++) begin
      if (w_enqSel[i]) begin
        r_qIndex[w_enqPtr[i]] <= upIndex[i*INDEX_WIDTH +: INDEX_WIDTH];
        r_qValue[w_enqPtr[i]] <= upValue[i*2 +: 2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Queue control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_dropCount <= '0;
    end else begin
      r_head      <= f_wrap(r_head, int'(w_drainNum));
      r_tail      <= f_wrap(r_tail, int'(w_enqNum));
      r_count     <= r_count - CNT_W'(w_drainNum) + CNT_W'(w_enqNum);
      r_dropCount <= f_satAdd(r_dropCount, w_dropNum);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Writes and the drop pulse are forced off while reset is held,
  // since the grant logic would otherwise bypass live inputs to the RAM.
  // ---------------------------------------------------------------------------
  assign wrValid   = rst_n ? w_wrValid : '0;
  assign wrIndex   = rst_n ? w_wrIndex : '0;
  assign wrValue   = rst_n ? w_wrValue : '0;
  assign dropped   = rst_n & (w_dropNum != '0);
  assign count     = r_count;
  assign full      = (r_count == CNT_W'(QUEUE_SIZE));
  assign dropCount = r_dropCount;

endmodule

// File: tb/tb_pht_update_scheduler.sv
module tb_pht_update_scheduler;

  localparam int IW = 10;
  localparam int QS = 32;
`ifdef RSD_PHT_UPDATE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  rdValid;
  logic [19:0] rdIndex;
  logic [1:0]  upValid;
  logic [19:0] upIndex;
  logic [3:0]  upValue;
  logic [1:0]  wrValid;
  logic [19:0] wrIndex;
  logic [3:0]  wrValue;
  logic [5:0]  count;
  logic        full;
  logic        dropped;
  logic [15:0] dropCount;

  pht_update_scheduler #(
    .READ_NUM(2), .WRITE_NUM(2), .INDEX_WIDTH(IW), .BANK_BITS(1), .QUEUE_SIZE(QS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rdValid(rdValid), .rdIndex(rdIndex),
    .upValid(upValid), .upIndex(upIndex), .upValue(upValue),
    .wrValid(wrValid), .wrIndex(wrIndex), .wrValue(wrValue),
    .count(count), .full(full), .dropped(dropped), .dropCount(dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: the queue as an SV queue of entries, plus a drop total.
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [1:0]    val;
  } ent_t;

  ent_t q[$];
  int   mDrop = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, predict, compare at the negedge, then
  // advance the model at the posedge. Called at posedge+1.
  task automatic step(input logic [1:0] rv, input logic [19:0] ri,
                      input logic [1:0] uv, input logic [19:0] ui,
                      input logic [3:0] uval, input bit chk);
    bit         busy [2];
    int         ng;
    int         drained;
    int         cap;
    int         ndrop;
    bit         stopped;
    ent_t       e;
    ent_t       pend[$];
    ent_t       keep[$];
    logic [1:0]  eV;
    logic [19:0] eI;
    logic [3:0]  eVal;

    rdValid = rv; rdIndex = ri; upValid = uv; upIndex = ui; upValue = uval;

    busy[0] = 1'b0; busy[1] = 1'b0;
    for (int i = 0; i < 2; i++) if (rv[i]) busy[ri[i*IW]] = 1'b1;
    eV = '0; eI = '0; eVal = '0; ng = 0;

    // Oldest queued entries first, stopping at the first one whose bank is taken.
    for (int k = 0; k < 2 && k < q.size(); k++) begin
      if (busy[q[k].idx[0]]) break;
      busy[q[k].idx[0]] = 1'b1;
      eV[ng] = 1'b1; eI[ng*IW +: IW] = q[k].idx; eVal[ng*2 +: 2] = q[k].val;
      ng++;
    end
    drained = ng;

    stopped = !BYPASS || (q.size() != 0);
    for (int i = 0; i < 2; i++) begin
      if (uv[i]) begin
        e.idx = ui[i*IW +: IW];
        e.val = uval[i*2 +: 2];
        if (!stopped && ng < 2 && !busy[e.idx[0]]) begin
          busy[e.idx[0]] = 1'b1;
          eV[ng] = 1'b1; eI[ng*IW +: IW] = e.idx; eVal[ng*2 +: 2] = e.val;
          ng++;
        end else begin
          stopped = 1'b1;
          pend.push_back(e);
        end
      end
    end

    cap = QS - q.size() + drained;
    ndrop = 0;
    foreach (pend[p]) begin
      if (cap > 0) begin keep.push_back(pend[p]); cap--; end
      else ndrop++;
    end

    @(negedge clk);
    if (chk) begin
      check("wrValid",   64'(wrValid),   64'(eV));
      check("wrIndex",   64'(wrIndex),   64'(eI));
      check("wrValue",   64'(wrValue),   64'(eVal));
      check("dropped",   64'(dropped),   64'(ndrop > 0));
      check("count",     64'(count),     64'(q.size()));
      check("full",      64'(full),      64'(q.size() == QS));
      check("dropCount", 64'(dropCount), 64'(mDrop));
    end

    @(posedge clk);
    repeat (drained) void'(q.pop_front());
    foreach (keep[p]) q.push_back(keep[p]);
    mDrop = (mDrop + ndrop > 65535) ? 65535 : mDrop + ndrop;
    #1;
  endtask

  task automatic idle();
    step(2'b00, 20'h0, 2'b00, 20'h0, 4'h0, 1'b1);
  endtask

  // Reset asserted in the middle of a cycle while updates are being presented.
  task automatic mid_reset();
    rdValid = 2'b00; upValid = 2'b11; upIndex = {10'h00B, 10'h00A}; upValue = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_count",     64'(count),     64'd0);
    check("rst_full",      64'(full),      64'd0);
    check("rst_wrValid",   64'(wrValid),   64'd0);
    check("rst_dropped",   64'(dropped),   64'd0);
    check("rst_dropCount", 64'(dropCount), 64'd0);
    q.delete();
    mDrop = 0;
    @(negedge clk);
    upValid = 2'b00;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  rv;
    logic [19:0] ri;

    rst_n = 1'b0; rdValid = 2'b00; rdIndex = '0;
    upValid = 2'b11; upIndex = {10'h005, 10'h004}; upValue = 4'b1001;
    #12;
    // Held in reset with live updates: nothing may reach the write ports.
    check("init_count",     64'(count),     64'd0);
    check("init_full",      64'(full),      64'd0);
    check("init_dropCount", 64'(dropCount), 64'd0);
    check("init_wrValid",   64'(wrValid),   64'd0);
    check("init_dropped",   64'(dropped),   64'd0);
    upValid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two updates to different banks, empty queue, no reads.
    step(2'b00, 20'h0, 2'b11, {10'h005, 10'h004}, {2'd2, 2'd1}, 1'b1);
    idle(); idle();

    // Update blocked by a read on its bank, drained the next cycle.
    step(2'b01, {10'h000, 10'h010}, 2'b01, {10'h000, 10'h020}, 4'h3, 1'b1);
    idle(); idle();

    // Two updates to the same bank.
    step(2'b00, 20'h0, 2'b11, {10'h004, 10'h002}, {2'd0, 2'd3}, 1'b1);
    idle(); idle();

    // Queue 0x001 then 0x002; head's bank read-blocked -> nothing skips it.
    step(2'b11, {10'h001, 10'h000}, 2'b11, {10'h002, 10'h001}, {2'd1, 2'd2}, 1'b1);
    step(2'b01, {10'h000, 10'h003}, 2'b00, 20'h0, 4'h0, 1'b1);
    idle(); idle();

    // Fill the queue with both banks read-blocked, then overflow it.
    for (int c = 0; c < 16; c++)
      step(2'b11, {10'h001, 10'h000}, 2'b11, 20'($urandom), 4'($urandom), 1'b1);
    check("full_reached", 64'(count), 64'd32);
    step(2'b11, {10'h001, 10'h000}, 2'b11, 20'($urandom), 4'($urandom), 1'b1);
    step(2'b11, {10'h001, 10'h000}, 2'b01, 20'($urandom), 4'($urandom), 1'b1);
    // Full queue, read only on bank 1: whatever drains frees same-cycle room.
    step(2'b01, {10'h000, 10'h001}, 2'b11, 20'($urandom), 4'($urandom), 1'b1);
    step(2'b11, {10'h001, 10'h000}, 2'b11, 20'($urandom), 4'($urandom), 1'b1);

    // Long overflow run to saturate the drop counter.
    for (int c = 0; c < 32800; c++)
      step(2'b11, {10'h001, 10'h000}, 2'b11, 20'($urandom), 4'($urandom), 1'b0);
    step(2'b11, {10'h001, 10'h000}, 2'b11, 20'($urandom), 4'($urandom), 1'b1);
    check("dropCount_sat", 64'(dropCount), 64'hFFFF);

    mid_reset();
    idle(); idle();

    // Five queued entries, then reset mid-cycle; no stale writes afterwards.
    step(2'b11, {10'h001, 10'h000}, 2'b11, {10'h011, 10'h010}, 4'h6, 1'b1);
    step(2'b11, {10'h001, 10'h000}, 2'b11, {10'h013, 10'h012}, 4'h9, 1'b1);
    step(2'b11, {10'h001, 10'h000}, 2'b01, {10'h000, 10'h014}, 4'h1, 1'b1);
    check("five_queued", 64'(count), 64'd5);
    mid_reset();
    idle(); idle(); idle();

    // Random traffic alternating read-heavy (fills) and read-light (drains).
    for (int c = 0; c < 800; c++) begin
      if (((c / 40) % 2) == 0) rv = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
      else                     rv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      ri = 20'($urandom);
      step(rv, ri, 2'($urandom), 20'($urandom), 4'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
